elastic_pipe_reg: RTL
=====================

Name: elastic_pipe_reg

Overview:
- Parametrised, chainable pipeline register for the pipelined CPU datapath (IF/ID, ID/EX, EX/MEM, MEM/WB class).
- Replaces fixed-field pipeline registers with one generic block: DATA_W-wide payload, STAGES deep, valid/ready handshake, stall and flush.
- Each stage is a 2-entry skid buffer, so in_ready_o never combinationally depends on out_ready_i.
- Pipeline control (hazard unit, branch resolution) drives stall_i and flush_i.

Parameters:
- DATA_W, 32, payload width in bits (1..256).
- STAGES, 1, number of chained skid stages (1..8); capacity is 2*STAGES entries.
- FLUSH_VALUE, 0, value loaded into every data register on reset or flush.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- flush_i  in  1  synchronous clear of all contents.
- stall_i  in  1  freeze: no handshakes on either side.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  block can accept.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_W  head payload.
- count_o  out  $clog2(2*STAGES+1)  entries currently held.

Behaviour:
- Reset (rst_i=0, asynchronous, takes effect immediately):
  - All stages go to EMPTY; data registers load FLUSH_VALUE.
  - out_valid_o=0, in_ready_o=1, count_o=0, out_data_o=FLUSH_VALUE.
  - Reset asserted mid-transfer discards everything; no partial state survives.
- Stage FSM (per stage; main register plus skid register):
  - EMPTY: push goes to HALF.
  - HALF: push without pop goes to FULL. Pop without push goes to EMPTY. Push and pop together stays HALF, with the new data going to main.
  - FULL: pop goes to HALF, and skid moves into main in the same edge. Push is never possible in FULL.
- Stage ready is registered: ready = (state != FULL).
- Stage k forwards to stage k+1 on an edge where stage k is non-EMPTY and stage k+1 is not FULL.
- Ordering is strict FIFO across the chain. No drops or duplicates except on flush or reset.
- External handshakes:
  - Input accept = in_valid_i & in_ready_o at the rising edge.
  - Output accept = out_valid_o & out_ready_i at the rising edge.
  - in_ready_o = stage0 not FULL & !stall_i & !flush_i.
  - out_valid_o = last stage non-EMPTY & !stall_i & !flush_i.
- Latency: data accepted into an empty pipe appears on out_valid_o exactly STAGES cycles later.
- Throughput: 1 entry/cycle when out_ready_i=1 continuously.
- Backpressure:
  - With out_ready_i=0, the block accepts exactly 2*STAGES entries, then in_ready_o=0.
  - After the first output accept at edge e, in_ready_o returns to 1 in the cycle following edge e+STAGES-1.
- count_o: next = count + input accept − output accept. Never exceeds 2*STAGES and never underflows.
- stall_i=1:
  - No internal moves and no external handshakes.
  - All state, data and count_o are held.
  - Deasserting stall resumes with no loss or duplication.
- flush_i=1:
  - At the next edge all stages go EMPTY, data registers load FLUSH_VALUE, count_o=0.
  - An input offered in the flush cycle is dropped; in_ready_o is 0 in that cycle.
  - Priority: reset > flush > stall > handshakes.
- out_data_o is defined only while out_valid_o=1, with one exception: after reset or flush, until the first new entry reaches the head, it equals FLUSH_VALUE.

Optional Feature:
- PIPE_PEAK_EN defined:
  - Adds output port peak_o, same width as count_o.
  - peak_o holds the maximum count_o since the last reset or flush, updated registered alongside count_o.
  - Reset/flush clears it to 0; stall holds it.
- PIPE_PEAK_EN undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_i=0 asynchronously mid-stream with 3 entries held (STAGES=2). Required: immediately out_valid_o=0, count_o=0, out_data_o=0; after release, in_ready_o=1.
- Streaming: STAGES=2, out_ready_i=1, push 0x1..0x8 back-to-back. Required: first out_valid_o 2 cycles after the first accept; outputs 0x1..0x8 one per cycle in order; count_o settles at 2.
- Backpressure: STAGES=2, out_ready_i=0, push continuously. Required: 4 accepts, then in_ready_o=0 with count_o=4. Raising out_ready_i drains 0x1..0x4 in order; in_ready_o returns 2 cycles after the first pop.
- Stall: during streaming, hold stall_i=1 for 3 cycles. Required: in_ready_o=0, out_valid_o=0, count_o constant; on resume the sequence continues with no gap value lost or repeated.
- Flush: 3 entries held, assert flush_i with in_valid_i=1 and stall_i=1 in the same cycle. Required: next cycle count_o=0, out_valid_o=0, out_data_o=FLUSH_VALUE; the offered word never appears at the output.
- PIPE_PEAK_EN: fill to count_o=3, drain to 0. Required: peak_o=3. Then flush; required: peak_o=0.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// Chainable elastic pipeline register: STAGES skid-buffer stages with valid/ready, stall and flush.
// Optional peak-occupancy output is compiled in when PIPE_PEAK_EN is defined.
module elastic_pipe_reg #(
  parameter int                DATA_W      = 32,
  parameter int                STAGES      = 1,
  parameter logic [DATA_W-1:0] FLUSH_VALUE = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic                              stall_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [DATA_W-1:0]                 in_data_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [DATA_W-1:0]                 out_data_o,
`ifdef PIPE_PEAK_EN
  output logic [$clog2(2*STAGES+1)-1:0]     count_o,
  output logic [$clog2(2*STAGES+1)-1:0]     peak_o
`else
  output logic [$clog2(2*STAGES+1)-1:0]     count_o
`endif
);

  localparam int CW = $clog2(2*STAGES+1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  logic                active;
  logic                in_acc;
  logic                out_acc;
  logic [STAGES-1:0]   nonempty;
  logic [STAGES-1:0]   full;
  logic [STAGES-1:0]   push;
  logic [STAGES-1:0]   pop;
  logic [DATA_W-1:0]   head_data [STAGES];
  logic [CW-1:0]       count_reg;
  logic [CW-1:0]       count_next;

  // Ready/valid only look at registered stage state plus stall/flush, never at out_ready_i.
  assign active      = ~stall_i & ~flush_i;
  assign in_ready_o  = ~full[0] & active;
  assign out_valid_o = nonempty[STAGES-1] & active;
  assign in_acc      = in_valid_i & in_ready_o;
  assign out_acc     = out_valid_o & out_ready_i;
  assign out_data_o  = head_data[STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      stage_state_t      state_reg;
      stage_state_t      state_next;
      logic [DATA_W-1:0] main_reg;
      logic [DATA_W-1:0] main_next;
      logic [DATA_W-1:0] skid_reg;
      logic [DATA_W-1:0] skid_next;
      logic [DATA_W-1:0] din;

      if (gi == 0) begin : g_first
        assign push[gi] = in_acc;
        assign din      = in_data_i;
      end else begin : g_chain
        assign push[gi] = pop[gi-1];
        assign din      = head_data[gi-1];
      end

      if (gi == STAGES-1) begin : g_last
        assign pop[gi] = out_acc;
      end else begin : g_mid
        assign pop[gi] = nonempty[gi] & ~full[gi+1] & active;
      end

      assign nonempty[gi]  = (state_reg != EMPTY);
      assign full[gi]      = (state_reg == FULL);
      assign head_data[gi] = main_reg;

      // main always holds the older entry; skid only fills when a push meets no pop.
      always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush_i) begin
          state_next = EMPTY;
          main_next  = FLUSH_VALUE;
          skid_next  = FLUSH_VALUE;
        end else begin
          case (state_reg)
            EMPTY: begin
              if (push[gi]) begin
                state_next = HALF;
                main_next  = din;
              end
            end
            HALF: begin
              if (push[gi] && pop[gi]) begin
                main_next = din;
              end else if (push[gi]) begin
                state_next = FULL;
                skid_next  = din;
              end else if (pop[gi]) begin
                state_next = EMPTY;
              end
            end
            FULL: begin
              if (pop[gi]) begin
                state_next = HALF;
                main_next  = skid_reg;
              end
            end
            default: state_next = EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          state_reg <= EMPTY;
          main_reg  <= FLUSH_VALUE;
          skid_reg  <= FLUSH_VALUE;
        end else begin
          state_reg <= state_next;
          main_reg  <= main_next;
          skid_reg  <= skid_next;
        end
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (flush_i) begin
      count_next = '0;
    end else begin
      count_next = count_reg + CW'(in_acc) - CW'(out_acc);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count_o = count_reg;

`ifdef PIPE_PEAK_EN
  logic [CW-1:0] peak_reg;
  logic [CW-1:0] peak_next;

  // Tracks against count_next so peak never lags the count it is shown beside.
  always_comb begin
    peak_next = peak_reg;
    if (flush_i) begin
      peak_next = '0;
    end else if (count_next > peak_reg) begin
      peak_next = count_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      peak_reg <= '0;
    end else begin
      peak_reg <= peak_next;
    end
  end

  assign peak_o = peak_reg;
`endif

endmodule
